// File: rtl/cla_nibble_seq.sv
// Multi-cycle WIDTH-bit adder sharing one 4-bit CLA slice, LSB nibble first.
// Optional subtract/overflow support via CLA_NIBBLE_SEQ_SUB_EN.
module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_NIBBLE_SEQ_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NIB-1:0][3:0] r_a;
  logic [NIB-1:0][3:0] r_b;
  logic [NIB-1:0][3:0] r_sum;
  logic                r_c;
  logic                r_cout;
  logic [IW-1:0]       r_idx;

  logic [3:0] w_an;
  logic [3:0] w_bn;
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_s;
  logic [4:0] w_c;
  logic       w_acc;
  logic       w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

`ifdef CLA_NIBBLE_SEQ_SUB_EN
  logic r_ovf;
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : cin;
  assign ovf    = r_ovf;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign w_acc  = in_valid && (r_state == IDLE);
  assign w_last = (r_idx == IW'(NIB - 1));

  assign w_an = r_a[r_idx];
  assign w_bn = r_b[r_idx];
  assign w_p  = w_an ^ w_bn;
  assign w_g  = w_an & w_bn;

  // Carry lookahead across the nibble
  assign w_c[0] = r_c;
  assign w_c[1] = w_g[0] | (w_p[0] & r_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & r_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (&w_p & r_c);
  assign w_s    = w_p ^ w_c[3:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_idx  <= '0;
`ifdef CLA_NIBBLE_SEQ_SUB_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_acc) begin
      r_a   <= a;
      r_b   <= w_b_in;
      r_c   <= w_c_in;
      r_idx <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx] <= w_s;
      r_c          <= w_c[4];
      r_idx        <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c[4];
`ifdef CLA_NIBBLE_SEQ_SUB_EN
        r_ovf  <= w_c[3] ^ w_c[4];
`endif
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed-vector bench for cla_nibble_seq (WIDTH=16).
// Subtract vectors are added when CLA_NIBBLE_SEQ_SUB_EN is defined.
module tb_cla_nibble_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef CLA_NIBBLE_SEQ_SUB_EN
  logic         sub = 1'b0;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] va,
                              input logic [W-1:0] vb,
                              input logic vc, input logic vs,
                              input logic [W-1:0] es,
                              input logic ec, input logic eo);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.sum = es; v.cout = ec; v.ovf = eo;
    return v;
  endfunction

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, lat, NIB);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    string nm;
    nm = $sformatf("vec%0d", k);
    for (int n = 0; n < 20 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    sub = v.sub;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin;
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    sub = ~v.sub;
`endif
    wait_out(nm, lat);
    check({nm, "_sum"}, sum, v.sum);
    check({nm, "_cout"}, cout, v.cout);
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    check({nm, "_ovf"}, ovf, v.ovf);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    vec_t vq[$];
    int lat;
    int stale;

    vq.push_back(mk(16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0));
    vq.push_back(mk(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0));
    vq.push_back(mk(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1));
    vq.push_back(mk(16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
    vq.push_back(mk(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0));
    vq.push_back(mk(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0));
    vq.push_back(mk(16'hABCD, 16'h1234, 0, 0, 16'hBE01, 0, 0));
`ifdef CLA_NIBBLE_SEQ_SUB_EN
    vq.push_back(mk(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0));
    vq.push_back(mk(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1));
`endif

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) run_vec(vq[i], i);

    // Stall in DONE with a stray request that must be ignored
    a = 16'h8000; b = 16'h8000; cin = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("stall", lat);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_sum", sum, 16'h0000);
      check("stall_cout", cout, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("stall_no_extra", busy, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    a = 16'h0102; b = 16'h0304; cin = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'h7FFF; b = 16'h0001; cin = 1;
    wait_out("b2b0", lat);
    check("b2b0_sum", sum, 16'h0406);
    check("b2b0_cout", cout, 1'b0);
    @(posedge clk); #1;
    check("b2b_gap_valid", out_valid, 1'b0);
    check("b2b_gap_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("b2b1_accepted", busy, 1'b1);
    in_valid = 1'b0;
    wait_out("b2b1", lat);
    check("b2b1_sum", sum, 16'h8001);
    check("b2b1_cout", cout, 1'b0);
    @(posedge clk); #1;
    check("b2b1_one_cycle", out_valid, 1'b0);
    out_ready = 1'b0;

    // Asynchronous reset in the second RUN cycle
    a = 16'hFFFF; b = 16'hFFFF; cin = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sum", sum, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1'b1);
    stale = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale++;
    end
    check("post_rst_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
